// File: rtl/paralelo_serial_pkg.sv
// -----------------------------------------------------------------------------
// paralelo_serial_pkg
// Definitions shared by the PHY transmit and receive paths:
//   K28_5            idle / synchronisation symbol (8'hBC)
//   N_COMMA_DEFAULT  number of consecutive commas the receiver needs to lock
//   link_state_e     transmitter link state (SYNC while sending the preamble,
//                    RUN once data may be sent)
//   is_comma()       symbol compare used wherever a word is tested for comma
// -----------------------------------------------------------------------------
package paralelo_serial_pkg;

  localparam logic [7:0] K28_5           = 8'hBC;
  localparam int         N_COMMA_DEFAULT = 4;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } link_state_e;

  function automatic logic is_comma(input logic [7:0] word,
                                    input logic [7:0] comma);
    return (word == comma);
  endfunction

endpackage : paralelo_serial_pkg

// File: rtl/paralelo_serial_phy_fifo.sv
// -----------------------------------------------------------------------------
// phy_fifo
// Small synchronous FIFO used by the PHY buffers. Circular buffer whose read
// and write pointers wrap modulo DEPTH (DEPTH must be a power of 2, >= 2).
// The head word is presented combinationally on rd_data; a pop consumes it.
// A push while full and a pop while empty are ignored, so callers cannot
// corrupt the occupancy count. A simultaneous push and pop leaves fill as is.
//
// Ports:
//   clk      clock
//   rst      asynchronous active-high reset (flushes the FIFO)
//   push     write wr_data at the tail this cycle
//   wr_data  word to write
//   pop      consume the head word this cycle
//   rd_data  current head word (valid while !empty)
//   fill     current occupancy, 0..DEPTH
//   full     fill == DEPTH
//   empty    fill == 0
// -----------------------------------------------------------------------------
module phy_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   FILL_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   FILL_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q,   fill_d;

  logic do_push;
  logic do_pop;

  assign full    = (fill_q == FILL_FULL);
  assign empty   = (fill_q == '0);
  assign fill    = fill_q;
  assign rd_data = mem_q[rd_ptr_q];

  assign do_push = push & ~full;
  assign do_pop  = pop  & ~empty;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;

    // Power-of-2 depth: pointer overflow is the modulo-DEPTH wrap.
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    unique case ({do_push, do_pop})
      2'b10:   fill_d = fill_q + FILL_ONE;
      2'b01:   fill_d = fill_q - FILL_ONE;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; a flush only clears the
  // pointers and count, and no entry is ever read before it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule : phy_fifo

// File: rtl/paralelo_serial.sv
// -----------------------------------------------------------------------------
// paralelo_serial
// PHY transmit serializer. Accepts 8-bit words over a valid/ready handshake,
// buffers them in a phy_fifo and shifts each word out MSB-first, two bits per
// clk16 cycle, four cycles per word. After reset or a resync request it first
// sends N_COMMA comma symbols so the receiver can lock; whenever no data is
// queued the line is filled with commas.
//
// Ports:
//   clk16      serial-rate clock, the only clock
//   reset16    asynchronous active-high reset
//   in_data    data word from the upstream stage
//   in_valid   in_data is valid this cycle
//   in_ready   FIFO can accept a word (push = in_valid && in_ready)
//   resync     one-cycle request to resend the comma preamble
//   serial     serial bit pair, most significant pair first (register output)
//   sync_done  high while the link is in RUN
//   err_comma  one-cycle pulse after a pushed word equal to COMMA
//   fill       current FIFO occupancy
//
// Timing: a word loaded at the load edge (phase == 3) appears on serial as
// [7:6],[5:4],[3:2],[1:0] in the four cycles that follow that edge. The word
// held in the shift register at reset counts as the first preamble comma.
// -----------------------------------------------------------------------------
module paralelo_serial
  import paralelo_serial_pkg::*;
#(
  parameter int         DEPTH   = 4,
  parameter int         N_COMMA = N_COMMA_DEFAULT,
  parameter logic [7:0] COMMA   = K28_5
) (
  input  logic                       clk16,
  input  logic                       reset16,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       resync,
  output logic [1:0]                 serial,
  output logic                       sync_done,
  output logic                       err_comma,
  output logic [$clog2(DEPTH):0]     fill
);

  localparam int CW = $clog2(N_COMMA + 1);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(N_COMMA);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]    phase_q,       phase_d;
  logic [7:0]    shreg_q,       shreg_d;
  logic [CW-1:0] comma_cnt_q,   comma_cnt_d;
  link_state_e   state_q,       state_d;
  logic          resync_pend_q, resync_pend_d;
  logic          err_comma_q,   err_comma_d;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic       push;
  logic       pop;
  logic [7:0] head;
  logic       fifo_full;
  logic       fifo_empty;

  // in_ready comes only from the registered occupancy, never from in_valid.
  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;

  phy_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk16),
    .rst     (reset16),
    .push    (push),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (head),
    .fill    (fill),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic load_edge;
  logic resync_now;

  assign load_edge  = (phase_q == 2'd3);
  // A request arriving on the load edge itself is honoured at that edge.
  assign resync_now = resync | resync_pend_q;

  always_comb begin
    phase_d       = phase_q + 2'd1;
    shreg_d       = {shreg_q[5:0], 2'b00};
    comma_cnt_d   = comma_cnt_q;
    state_d       = state_q;
    resync_pend_d = resync_pend_q | resync;
    pop           = 1'b0;
    err_comma_d   = push & is_comma(in_data, COMMA);

    if (load_edge) begin
      resync_pend_d = 1'b0;
      if (resync_now) begin
        // Restart the preamble; the comma loaded here is comma number one.
        state_d     = SYNC;
        comma_cnt_d = CNT_ONE;
        shreg_d     = COMMA;
      end else if ((state_q == SYNC) && (comma_cnt_q < CNT_MAX)) begin
        shreg_d     = COMMA;
        comma_cnt_d = comma_cnt_q + CNT_ONE;
      end else begin
        // RUN, or SYNC with the preamble complete: enter RUN and serve the
        // FIFO at this same edge. fifo_empty reflects the pre-edge count, so
        // a word pushed on this edge waits for the next load edge.
        state_d = RUN;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = head;
        end else begin
          shreg_d = COMMA;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk16 or posedge reset16) begin
    if (reset16) begin
      phase_q       <= 2'd0;
      shreg_q       <= COMMA;
      comma_cnt_q   <= CNT_ONE;
      state_q       <= SYNC;
      resync_pend_q <= 1'b0;
      err_comma_q   <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      shreg_q       <= shreg_d;
      comma_cnt_q   <= comma_cnt_d;
      state_q       <= state_d;
      resync_pend_q <= resync_pend_d;
      err_comma_q   <= err_comma_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, all taken directly from registers
  // ---------------------------------------------------------------------------
  assign serial    = shreg_q[7:6];
  assign sync_done = (state_q == RUN);
  assign err_comma = err_comma_q;

endmodule : paralelo_serial

// File: tb/tb_paralelo_serial.sv
// -----------------------------------------------------------------------------
// tb_paralelo_serial
// Self-checking bench for paralelo_serial (DEPTH=4, N_COMMA=4, COMMA=8'hBC).
// Stimulus pushes the data words it expects to see into exp_q; an independent
// monitor reassembles every four-cycle word from serial and compares each
// non-comma word with the head of exp_q. Directed checks cover the comma
// preamble, line timing, flow control, resync, err_comma and reset.
// Cycle n is the interval following the n-th rising edge after reset release.
// -----------------------------------------------------------------------------
module tb_paralelo_serial;

  localparam logic [7:0] COMMA = 8'hBC;

  logic       clk16    = 1'b0;
  logic       reset16  = 1'b1;
  logic [7:0] in_data  = 8'h00;
  logic       in_valid = 1'b0;
  logic       resync   = 1'b0;
  logic       in_ready;
  logic [1:0] serial;
  logic       sync_done;
  logic       err_comma;
  logic [2:0] fill;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] exp_q [$];

  // Hand-derived bit-pair sequences, most significant pair first.
  logic [1:0] idle_pat [4] = '{2'b10, 2'b11, 2'b11, 2'b00};  // 8'hBC
  logic [1:0] a5_pat   [4] = '{2'b10, 2'b10, 2'b01, 2'b01};  // 8'hA5
  logic [1:0] h11_pat  [4] = '{2'b00, 2'b01, 2'b00, 2'b01};  // 8'h11
  logic [1:0] h3c_pat  [4] = '{2'b00, 2'b11, 2'b11, 2'b00};  // 8'h3C

  paralelo_serial #(
    .DEPTH   (4),
    .N_COMMA (4),
    .COMMA   (8'hBC)
  ) dut (
    .clk16     (clk16),
    .reset16   (reset16),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .resync    (resync),
    .serial    (serial),
    .sync_done (sync_done),
    .err_comma (err_comma),
    .fill      (fill)
  );

  always #5 clk16 = ~clk16;

  always @(posedge clk16 or posedge reset16) begin
    if (reset16) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to the falling edge inside cycle n (bounded).
  task automatic at_neg(input int n);
    int g = 0;
    do begin
      @(negedge clk16);
      g++;
    end while (cyc != n && g < 1000);
    if (cyc != n) begin
      n_tests++;
      n_fail++;
      $display("FAIL cycle_wait: at cycle %0d, expected cycle %0d", cyc, n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk16);
    #2;
    reset16  = 1'b1;
    in_valid = 1'b0;
    resync   = 1'b0;
    exp_q.delete();
    #1;
    check("rst_serial",    32'(serial),    32'(2'b10));
    check("rst_fill",      32'(fill),      32'(0));
    check("rst_in_ready",  32'(in_ready),  32'(1));
    check("rst_sync_done", 32'(sync_done), 32'(0));
    check("rst_err_comma", 32'(err_comma), 32'(0));
    repeat (3) @(posedge clk16);
    #1 reset16 = 1'b0;
  endtask

  // Monitor: rebuild each word and score every non-comma word in order.
  initial begin
    logic [7:0] acc;
    logic [7:0] exp_w;
    acc = 8'h00;
    forever begin
      @(negedge clk16);
      if (!reset16) begin
        if (cyc % 4 == 0) acc = {6'b000000, serial};
        else              acc = {acc[5:0], serial};
        if ((cyc % 4 == 3) && (acc != COMMA)) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_word: got 0x%0h, expected comma 0x%0h (cycle %0d)",
                     acc, COMMA, cyc);
          end else begin
            exp_w = exp_q.pop_front();
            check("data_word", 32'(acc), 32'(exp_w));
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] nxt;
    int         sent;

    // 1: idle line after reset, preamble then commas.
    do_reset();
    for (int n = 0; n < 40; n++) begin
      at_neg(n);
      check("t1_serial",    32'(serial),    32'(idle_pat[n % 4]));
      check("t1_sync_done", 32'(sync_done), 32'(n >= 16));
    end

    // 2: single word 8'hA5 pushed in cycle 2.
    do_reset();
    at_neg(2);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    exp_q.push_back(8'hA5);
    at_neg(3);
    in_valid = 1'b0;
    check("t2_fill_push", 32'(fill), 32'(1));
    for (int n = 4; n < 24; n++) begin
      at_neg(n);
      if (n >= 16 && n <= 19) check("t2_serial_a5", 32'(serial), 32'(a5_pat[n - 16]));
      else                    check("t2_serial_idle", 32'(serial), 32'(idle_pat[n % 4]));
      if (n == 10) check("t2_fill_held", 32'(fill), 32'(1));
      if (n == 16) check("t2_fill_pop",  32'(fill), 32'(0));
    end

    // 3: continuous valid with incrementing data, back-pressure.
    do_reset();
    nxt  = 8'h10;
    sent = 0;
    for (int n = 0; n < 60; n++) begin
      at_neg(n);
      if (sent < 10) begin
        in_valid = 1'b1;
        in_data  = nxt;
        if (in_ready) begin
          exp_q.push_back(nxt);
          nxt++;
          sent++;
        end
      end else begin
        in_valid = 1'b0;
      end
      if (n == 4)  check("t3_fill_full",   32'(fill),     32'(4));
      if (n == 4)  check("t3_ready_full",  32'(in_ready), 32'(0));
      if (n == 15) check("t3_ready_held",  32'(in_ready), 32'(0));
      if (n == 16) check("t3_ready_pop",   32'(in_ready), 32'(1));
      if (n == 16) check("t3_fill_pop",    32'(fill),     32'(3));
      if (n == 17) check("t3_ready_refill", 32'(in_ready), 32'(0));
      if (n >= 20 && n <= 23) check("t3_serial_11", 32'(serial), 32'(h11_pat[n - 20]));
      if (n == 57) check("t3_fill_drained", 32'(fill), 32'(0));
      if (n == 57) check("t3_all_words_seen", 32'(exp_q.size()), 32'(0));
    end

    // 4: resync in cycle 30 with four words queued.
    do_reset();
    nxt  = 8'hD0;
    sent = 0;
    for (int n = 0; n < 66; n++) begin
      at_neg(n);
      if (sent < 8) begin
        in_valid = 1'b1;
        in_data  = nxt;
        if (in_ready) begin
          exp_q.push_back(nxt);
          nxt++;
          sent++;
        end
      end else begin
        in_valid = 1'b0;
      end
      resync = (n == 30);
      if (n == 30) check("t4_fill_queued", 32'(fill), 32'(4));
      if (n == 31) check("t4_sync_before", 32'(sync_done), 32'(1));
      if (n >= 32 && n <= 47) begin
        check("t4_serial_comma", 32'(serial),    32'(idle_pat[n % 4]));
        check("t4_sync_low",     32'(sync_done), 32'(0));
      end
      if (n == 40) check("t4_fifo_kept",  32'(fill),      32'(4));
      if (n == 48) check("t4_sync_again", 32'(sync_done), 32'(1));
      if (n == 48) check("t4_fill_pop",   32'(fill),      32'(3));
      if (n == 65) check("t4_all_words_seen", 32'(exp_q.size()), 32'(0));
    end

    // 5: a pushed comma raises err_comma once and still occupies a slot.
    do_reset();
    for (int n = 0; n < 34; n++) begin
      at_neg(n);
      in_valid = (n == 20) || (n == 21);
      if (n == 20) in_data = 8'hBC;
      if (n == 21) begin
        in_data = 8'h3C;
        exp_q.push_back(8'h3C);
      end
      if (n >= 20 && n <= 23) check("t5_err_comma", 32'(err_comma), 32'(n == 21));
      if (n == 22) check("t5_fill_two",  32'(fill), 32'(2));
      if (n == 24) check("t5_fill_one",  32'(fill), 32'(1));
      if (n == 28) check("t5_fill_zero", 32'(fill), 32'(0));
      if (n >= 28 && n <= 31) check("t5_serial_3c", 32'(serial), 32'(h3c_pat[n - 28]));
      if (n == 33) check("t5_all_words_seen", 32'(exp_q.size()), 32'(0));
    end

    // 6: reset in the middle of a word with data still queued.
    do_reset();
    for (int n = 0; n < 22; n++) begin
      at_neg(n);
      in_valid = (n >= 2) && (n <= 4);
      if (n == 2) in_data = 8'hA1;
      if (n == 3) in_data = 8'hB2;
      if (n == 4) in_data = 8'hC3;
      if (n >= 2 && n <= 4) exp_q.push_back(in_data);
      if (n == 21) check("t6_fill_before", 32'(fill), 32'(1));
    end
    do_reset();
    for (int n = 0; n < 20; n++) begin
      at_neg(n);
      check("t6_serial", 32'(serial), 32'(idle_pat[n % 4]));
      if (n == 0)  check("t6_fill_flushed", 32'(fill),      32'(0));
      if (n == 15) check("t6_sync_low",     32'(sync_done), 32'(0));
      if (n == 16) check("t6_sync_high",    32'(sync_done), 32'(1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule : tb_paralelo_serial
